// File: rtl/pc_redirect_controller_pkg.sv
// Shared types and constants for the PC redirect controller slice.
package pc_redirect_controller_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int XLEN      = 32;
  localparam int PC_STEP   = 4;
  localparam int REG_IDX_W = 5;

  // Width of the flush down-counter; a single-cycle flush still needs one bit.
  function automatic int flush_cnt_width(input int flush_cycles);
    int w;
    w = $clog2(flush_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/redirect_priority_arbiter.sv
// Fixed-priority one-hot grant: the lowest-indexed valid requester wins.
module redirect_priority_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // Walk from index 0 upward and grant only the first valid requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_controller.sv
// PC redirect controller: owns the architectural PC, arbitrates jump/branch
// redirects, writes the link register and flushes fetch for FLUSH_CYCLES.
// Optional feature macro PC_REDIRECT_COMPRESSED_EN allows 2-byte-aligned
// targets and removes the misaligned-target exception.
module pc_redirect_controller
  import pc_redirect_controller_pkg::*;
#(
  parameter int          NUM_REQ      = 3,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_target,
  input  logic [NUM_REQ*32-1:0]    req_link,
  input  logic [NUM_REQ*5-1:0]     req_rd,
  input  logic                     pc_advance,
  output logic [31:0]              pc_out,
  output logic                     fetch_flush,
  output logic                     rd_write_enable,
  output logic [4:0]               rd_index,
  output logic [31:0]              rd_value,
  output logic                     misaligned_exception,
  output logic [31:0]              exception_pc,
  output logic                     busy
);

  localparam int                CNT_W    = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_REQ-1:0]     arb_grant;
  logic                   accept;
  logic [XLEN-1:0]        sel_target, sel_link, eff_target;
  logic [REG_IDX_W-1:0]   sel_rd;
  logic                   target_misaligned;
  logic [XLEN-1:0]        pc_nxt, rd_value_nxt, exception_pc_nxt;
  logic [REG_IDX_W-1:0]   rd_index_nxt;
  logic                   rd_we_nxt, exc_nxt;

  redirect_priority_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
    .req_valid (req_valid),
    .grant     (arb_grant)
  );

  // Grants are only visible while idle; during a flush every requester waits.
  assign req_ready   = arb_grant & {NUM_REQ{state == IDLE}};
  assign accept      = |req_ready;
  assign fetch_flush = (state == FLUSH);
  assign busy        = (state != IDLE);

  // One-hot mux of the granted requester's target, link value and rd.
  always_comb begin
    sel_target = '0;
    sel_link   = '0;
    sel_rd     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_target = sel_target | req_target[i*XLEN +: XLEN];
        sel_link   = sel_link   | req_link[i*XLEN +: XLEN];
        sel_rd     = sel_rd     | req_rd[i*REG_IDX_W +: REG_IDX_W];
      end
    end
  end

  // jalr semantics: bit 0 of the target is always discarded.
  assign eff_target = sel_target & ~XLEN'(1);

`ifdef PC_REDIRECT_COMPRESSED_EN
  assign target_misaligned = 1'b0;
`else
  assign target_misaligned = eff_target[1];
`endif

  // Next-state and next-output logic; strobes default low, held values default to hold.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    pc_nxt           = pc_out;
    rd_we_nxt        = 1'b0;
    rd_index_nxt     = rd_index;
    rd_value_nxt     = rd_value;
    exc_nxt          = 1'b0;
    exception_pc_nxt = exception_pc;
    case (state)
      IDLE: begin
        if (accept) begin
          if (target_misaligned) begin
            exc_nxt          = 1'b1;
            exception_pc_nxt = eff_target;
          end else begin
            pc_nxt       = eff_target;
            rd_we_nxt    = (sel_rd != '0);
            rd_index_nxt = sel_rd;
            rd_value_nxt = sel_link;
            state_nxt    = FLUSH;
            cnt_nxt      = CNT_LOAD;
          end
        end else if (pc_advance) begin
          pc_nxt = pc_out + XLEN'(PC_STEP);
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      pc_out               <= RESET_PC;
      rd_write_enable      <= 1'b0;
      rd_index             <= '0;
      rd_value             <= '0;
      misaligned_exception <= 1'b0;
      exception_pc         <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      pc_out               <= pc_nxt;
      rd_write_enable      <= rd_we_nxt;
      rd_index             <= rd_index_nxt;
      rd_value             <= rd_value_nxt;
      misaligned_exception <= exc_nxt;
      exception_pc         <= exception_pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Self-checking bench for pc_redirect_controller with a behavioural model.
module tb_pc_redirect_controller;

  localparam int          NUM_REQ = 3;
  localparam int          FC      = 2;
  localparam logic [31:0] RPC     = 32'h0000_0100;

  logic               clock = 1'b0;
  logic               reset;
  logic [2:0]         req_valid;
  logic [2:0]         req_ready;
  logic [95:0]        req_target;
  logic [95:0]        req_link;
  logic [14:0]        req_rd;
  logic               pc_advance;
  logic [31:0]        pc_out;
  logic               fetch_flush;
  logic               rd_write_enable;
  logic [4:0]         rd_index;
  logic [31:0]        rd_value;
  logic               misaligned_exception;
  logic [31:0]        exception_pc;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pc_redirect_controller #(
    .NUM_REQ(NUM_REQ), .FLUSH_CYCLES(FC), .RESET_PC(RPC)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_link(req_link), .req_rd(req_rd),
    .pc_advance(pc_advance), .pc_out(pc_out), .fetch_flush(fetch_flush),
    .rd_write_enable(rd_write_enable), .rd_index(rd_index), .rd_value(rd_value),
    .misaligned_exception(misaligned_exception), .exception_pc(exception_pc),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_pc, m_rd_val, m_exc_pc, m_tgt;
  logic [4:0]  m_rd_idx;
  logic        m_rd_we, m_exc;
  logic [2:0]  m_grant;
  int          m_left;
  int          m_sel;

`ifdef PC_REDIRECT_COMPRESSED_EN
  localparam bit COMPRESSED = 1'b1;
`else
  localparam bit COMPRESSED = 1'b0;
`endif

  function automatic logic [2:0] lowest_set(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: what each output must be after this edge, from the rules alone
  always @(posedge clock) begin
    if (reset) begin
      m_valid  = 1'b1;
      m_pc     = RPC;
      m_left   = 0;
      m_rd_we  = 1'b0;
      m_rd_idx = '0;
      m_rd_val = '0;
      m_exc    = 1'b0;
      m_exc_pc = '0;
    end else if (m_valid) begin
      m_rd_we = 1'b0;
      m_exc   = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else begin
        m_grant = lowest_set(req_valid);
        if (m_grant != 3'b000) begin
          m_sel = (m_grant == 3'b001) ? 0 : (m_grant == 3'b010) ? 1 : 2;
          m_tgt = req_target[m_sel*32 +: 32] & 32'hFFFF_FFFE;
          if (COMPRESSED || (m_tgt % 4 == 0)) begin
            m_pc     = m_tgt;
            m_left   = FC;
            m_rd_idx = req_rd[m_sel*5 +: 5];
            m_rd_val = req_link[m_sel*32 +: 32];
            m_rd_we  = (m_rd_idx != 5'd0);
          end else begin
            m_exc    = 1'b1;
            m_exc_pc = m_tgt;
          end
        end else if (pc_advance) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clock) begin
    if (m_valid) begin
      checkOutput("pc_out", pc_out, m_pc);
      checkOutput("fetch_flush", {31'd0, fetch_flush}, {31'd0, m_left > 0});
      checkOutput("busy", {31'd0, busy}, {31'd0, m_left > 0});
      checkOutput("rd_write_enable", {31'd0, rd_write_enable}, {31'd0, m_rd_we});
      checkOutput("rd_index", {27'd0, rd_index}, {27'd0, m_rd_idx});
      checkOutput("rd_value", rd_value, m_rd_val);
      checkOutput("misaligned_exception", {31'd0, misaligned_exception}, {31'd0, m_exc});
      checkOutput("exception_pc", exception_pc, m_exc_pc);
      checkOutput("req_ready", {29'd0, req_ready},
                  {29'd0, (m_left > 0) ? 3'b000 : lowest_set(req_valid)});
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setReq(input int i, input logic [31:0] tgt, input logic [31:0] link, input logic [4:0] rd);
    req_target[i*32 +: 32] = tgt;
    req_link[i*32 +: 32]   = link;
    req_rd[i*5 +: 5]       = rd;
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic adv);
    req_valid  = valid;
    pc_advance = adv;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_target = '0;
    req_link   = '0;
    req_rd     = '0;
    pc_advance = 1'b0;
    tick(2);
    reset = 1'b0;
    checkOutput("lit_reset_pc", pc_out, 32'h100);
    checkOutput("lit_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("lit_reset_flush", {31'd0, fetch_flush}, 32'd0);
    checkOutput("lit_reset_exc_pc", exception_pc, 32'd0);

    applyStimulus(3'b000, 1'b1);
    tick(3);
    checkOutput("lit_advance3", pc_out, 32'h10C);

    setReq(1, 32'h2001, 32'h10C, 5'd1);
    applyStimulus(3'b010, 1'b0);
    checkOutput("lit_ready_single", {29'd0, req_ready}, 32'h2);
    tick(1);
    checkOutput("lit_jalr_pc", pc_out, 32'h2000);
    checkOutput("lit_jalr_we", {31'd0, rd_write_enable}, 32'd1);
    checkOutput("lit_jalr_idx", {27'd0, rd_index}, 32'd1);
    checkOutput("lit_jalr_val", rd_value, 32'h10C);
    applyStimulus(3'b000, 1'b0);
    tick(1);
    checkOutput("lit_jalr_we_pulse", {31'd0, rd_write_enable}, 32'd0);
    checkOutput("lit_flush_c2", {31'd0, fetch_flush}, 32'd1);
    tick(1);
    checkOutput("lit_flush_done", {31'd0, fetch_flush}, 32'd0);
    checkOutput("lit_busy_done", {31'd0, busy}, 32'd0);

    setReq(1, 32'h400, 32'h111, 5'd2);
    setReq(2, 32'h800, 32'h222, 5'd3);
    applyStimulus(3'b110, 1'b0);
    checkOutput("lit_ready_prio", {29'd0, req_ready}, 32'h2);
    tick(1);
    checkOutput("lit_prio_pc", pc_out, 32'h400);
    applyStimulus(3'b100, 1'b0);
    checkOutput("lit_ready_flush", {29'd0, req_ready}, 32'h0);
    tick(2);
    checkOutput("lit_ready_held", {29'd0, req_ready}, 32'h4);
    tick(1);
    checkOutput("lit_held_pc", pc_out, 32'h800);
    applyStimulus(3'b000, 1'b0);
    tick(2);

    setReq(0, 32'h3006, 32'h123, 5'd5);
    applyStimulus(3'b001, 1'b0);
    tick(1);
`ifdef PC_REDIRECT_COMPRESSED_EN
    checkOutput("lit_c_pc", pc_out, 32'h3006);
    checkOutput("lit_c_exc", {31'd0, misaligned_exception}, 32'd0);
`else
    checkOutput("lit_mis_exc", {31'd0, misaligned_exception}, 32'd1);
    checkOutput("lit_mis_exc_pc", exception_pc, 32'h3006);
    checkOutput("lit_mis_pc", pc_out, 32'h800);
    checkOutput("lit_mis_we", {31'd0, rd_write_enable}, 32'd0);
`endif
    applyStimulus(3'b000, 1'b0);
    tick(2);

    setReq(0, 32'h5000, 32'h456, 5'd0);
    applyStimulus(3'b001, 1'b1);
    tick(1);
    checkOutput("lit_rd0_pc", pc_out, 32'h5000);
    checkOutput("lit_rd0_we", {31'd0, rd_write_enable}, 32'd0);
    applyStimulus(3'b000, 1'b1);
    tick(2);
    checkOutput("lit_flush_ignores_adv", pc_out, 32'h5000);
    applyStimulus(3'b000, 1'b0);

    setReq(0, 32'h6000, 32'h789, 5'd4);
    applyStimulus(3'b001, 1'b0);
    tick(1);
    applyStimulus(3'b000, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("lit_midreset_pc", pc_out, 32'h100);
    checkOutput("lit_midreset_flush", {31'd0, fetch_flush}, 32'd0);
    checkOutput("lit_midreset_busy", {31'd0, busy}, 32'd0);

    setReq(0, 32'hFFFF_FFFC, 32'h0, 5'd0);
    applyStimulus(3'b001, 1'b0);
    tick(1);
    applyStimulus(3'b000, 1'b0);
    tick(2);
    checkOutput("lit_top_pc", pc_out, 32'hFFFF_FFFC);
    applyStimulus(3'b000, 1'b1);
    tick(1);
    checkOutput("lit_wrap_pc", pc_out, 32'h0);
    applyStimulus(3'b000, 1'b0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_controller.md
Name: pc_redirect_controller

Overview:
- Owns the architectural PC and sequences control-flow redirects raised by the jump and branch ALUs (jal, jalr, conditional branches).
- Arbitrates simultaneous redirect requests with fixed priority, then checks target alignment.
- Updates the PC, writes the link register, and flushes the fetch stage for a fixed number of cycles.
- Sits between the execute-stage control-flow ALUs and instruction fetch.

Parameters:
NUM_REQ, 3, number of redirect requesters; index 0 has the highest priority.
FLUSH_CYCLES, 2, cycles fetch_flush stays high after a redirect (minimum 1).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester redirect request
req_ready  output  NUM_REQ  per-requester grant; combinational
req_target  input  NUM_REQ*32  packed jump targets; requester i occupies bits [32i+31:32i]
req_link  input  NUM_REQ*32  packed link values (pc+4) to write to rd
req_rd  input  NUM_REQ*5  packed destination register indices
pc_advance  input  1  fetch consumed one instruction; PC steps sequentially
pc_out  output  32  current architectural PC
fetch_flush  output  1  discard in-flight fetch
rd_write_enable  output  1  one-cycle link write strobe
rd_index  output  5  link destination register
rd_value  output  32  link value
misaligned_exception  output  1  one-cycle misaligned-target pulse
exception_pc  output  32  offending target, held until the next exception
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (synchronous):
  - state=IDLE, flush counter=0, pc_out=RESET_PC.
  - All other outputs 0, including exception_pc.
  - Reset asserted mid-FLUSH abandons the flush. No rd write or exception is emitted in the reset cycle.
- States are IDLE and FLUSH.
- req_ready[i]:
  - Equals state==IDLE AND req_valid[i] AND no req_valid[j] with j<i.
  - At most one bit is high. All bits are 0 in FLUSH.
  - Non-granted requesters must hold their request; there is no queuing.
- Accept = any req_valid & req_ready. The effective target is req_target[i] with bit0 forced to 0 (jalr semantics).
- Accept with effective target[1]==0, next cycle:
  - pc_out<=target, fetch_flush<=1.
  - rd_write_enable<=(rd!=0); rd_index and rd_value registered from the granted requester.
  - state<=FLUSH, counter<=FLUSH_CYCLES-1.
- Accept with effective target[1]==1 (macro off), next cycle:
  - misaligned_exception<=1, exception_pc<=effective target.
  - PC unchanged, no rd write, no flush; state stays IDLE.
- FLUSH:
  - fetch_flush stays high.
  - Counter decrements each cycle. When counter==0, next cycle state<=IDLE and fetch_flush<=0.
  - Total flush pulse is exactly FLUSH_CYCLES cycles.
  - pc_advance is ignored.
- IDLE with no accept and pc_advance=1: pc_out<=pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- An accepted redirect and pc_advance in the same cycle: the redirect wins and the advance is dropped.
- rd_write_enable and misaligned_exception are single-cycle pulses; rd_index and rd_value hold their last values.
- Link value is taken verbatim from req_link; the controller does no arithmetic on it.
- Latency from accept to new pc_out is 1 cycle.

Optional Feature:
- Macro: PC_REDIRECT_COMPRESSED_EN.
- Defined: 2-byte-aligned targets are legal. Only bit0 is cleared, target[1] is never checked, and misaligned_exception is tied to 0.
- Not defined: 4-byte alignment is enforced as described in Behaviour.

Decomposition:
- Shared package:
  - state enum {IDLE, FLUSH}.
  - PC_STEP=4, XLEN=32, REG_IDX_W=5.
  - FLUSH counter width function: clog2(FLUSH_CYCLES).
- Sub-module: redirect_priority_arbiter.
  - Parameterised NUM_REQ fixed-priority one-hot grant from req_valid.
  - The top level gates its output with state==IDLE.

Test Plan:
- Reset:
  - Assert reset 2 cycles, RESET_PC=32'h100 -> pc_out=32'h100, all strobes 0, busy 0.
  - Then 3 pc_advance pulses -> pc_out=32'h10C.
- Single jalr-style redirect: req_valid=3'b010, target=32'h2001, link=32'h10C, rd=1 ->
  - req_ready=3'b010.
  - Next cycle pc_out=32'h2000, rd_write_enable=1 for 1 cycle with rd_index=1 and rd_value=32'h10C.
  - fetch_flush high for exactly 2 cycles, busy high for 2 cycles.
- Simultaneous requests: req_valid=3'b110 with targets 32'h400/32'h800 -> req_ready=3'b010, pc_out=32'h400; requester 2 held until IDLE, then pc_out=32'h800.
- Misaligned, macro off: target=32'h3006 -> misaligned_exception pulses 1 cycle, exception_pc=32'h3006, pc_out unchanged, no rd write.
  - Same stimulus with macro on -> pc_out=32'h3006, no exception.
- rd=0 redirect combined with pc_advance in the same cycle -> pc_out=target (advance dropped), rd_write_enable stays 0.
- Mid-operation conditions:
  - Reset asserted on the second FLUSH cycle -> next cycle pc_out=RESET_PC, fetch_flush=0, busy=0.
  - Separately, pc_out=32'hFFFF_FFFC with pc_advance -> pc_out=0.
